// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding for the unified-memory arbiter
package mem_pkg;
  typedef logic state_t;
  localparam state_t ST_NORM = 1'b0;
  localparam state_t ST_CONT = 1'b1;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: counts consecutive denied fetch cycles, saturating at MAX_WAIT
module arb_wait_counter #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic starve
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !hold && cnt != W'(MAX_WAIT)) cnt <= cnt + 1'b1;
  assign starve = cnt == W'(MAX_WAIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one async-read memory between fetch and two-beat-capable data accesses
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int ADDR_STEP = 1,
  parameter int MAX_WAIT  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_gnt,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_cont,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_gnt,
  output logic          d_beat,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_t state;
  logic   cont, starve, d_ok;
  assign cont = state == ST_CONT;
  assign d_ok = d_req & ~flush;
  // the second beat is locked: fetch can never slip in between the two beats
  assign d_gnt    = d_ok & (cont | ~(if_req & starve));
  assign if_gnt   = if_req & ~cont & (starve | ~d_ok);
  assign d_beat   = d_gnt & cont;
  assign if_stall = if_req & ~if_gnt;
  assign d_stall  = d_req & ~(d_gnt & (cont | ~d_cont));
  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? (cont ? d_addr + AW'(ADDR_STEP) : d_addr) : if_gnt ? if_addr : '0;
  assign mem_wdata = d_gnt ? d_wdata : '0;
  assign if_rdata  = if_gnt ? mem_rdata : '0;
  assign d_rdata   = d_gnt ? mem_rdata : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_NORM;
    else state <= (~cont & d_gnt & d_cont) ? ST_CONT : ST_NORM;
  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_stall),
    .clr   (~if_req | if_gnt),
    .hold  (cont),
    .starve(starve)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized + directed scoreboard bench against a transaction-level arbitration model
module tb_mem_arbiter;
  localparam int MAXW = 3;
  logic        clk = 1'b0;
  logic        rst, flush, if_req, d_req, d_we, d_cont;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_gnt, if_stall, d_gnt, d_beat, d_stall, mem_en, mem_we;

  mem_arbiter #(.AW(32), .DW(32), .ADDR_STEP(1), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_gnt(if_gnt), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_cont(d_cont), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_gnt(d_gnt), .d_beat(d_beat), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction
  assign mem_rdata = memf(mem_addr);

  typedef struct packed {
    logic ig, dg, beat, ist, dst, en, we;
    logic [31:0] addr, wd, ird, drd;
  } obs_t;
  obs_t q[$];
  int checks = 0, passed = 0, cyc = 0;

  // reference model: is a second beat owed, and how long has fetch been kept waiting
  bit locked = 0;
  int waited = 0;
  bit v_rst, v_ir, v_dr, v_we, v_ct, v_fl;
  logic [31:0] v_ia, v_da, v_w0, v_w1;
  bit m_ig, m_dg, m_beat;

  task automatic clr_in();
    v_rst = 0; v_ir = 0; v_dr = 0; v_we = 0; v_ct = 0; v_fl = 0;
    v_ia = 0; v_da = 0; v_w0 = 0; v_w1 = 0;
  endtask

  task automatic tick();
    obs_t e;
    bit ig, dg, beat;
    logic [31:0] a, wd;
    @(posedge clk); #1;
    if (v_rst) begin locked = 0; waited = 0; end
    wd = locked ? v_w1 : v_w0;
    rst = v_rst; flush = v_fl; if_req = v_ir; if_addr = v_ia;
    d_req = v_dr; d_we = v_we; d_cont = v_ct; d_addr = v_da; d_wdata = wd;
    ig = 0; dg = 0; beat = locked;
    if (locked) dg = v_dr && !v_fl;
    else if (v_ir && waited >= MAXW) ig = 1;
    else if (v_dr && !v_fl) dg = 1;
    else if (v_ir) ig = 1;
    a = dg ? v_da + (beat ? 32'd1 : 32'd0) : ig ? v_ia : 32'd0;
    e.ig = ig; e.dg = dg; e.beat = dg && beat;
    e.ist = v_ir && !ig;
    e.dst = v_dr && !(dg && (beat || !v_ct));
    e.en = ig || dg; e.we = dg && v_we;
    e.addr = a; e.wd = dg ? wd : 32'd0;
    e.ird = ig ? memf(a) : 32'd0;
    e.drd = dg ? memf(a) : 32'd0;
    q.push_back(e);
    if (!v_ir || ig) waited = 0;
    else if (!locked && waited < MAXW) waited++;
    locked = !locked && dg && v_ct;
    if (v_rst) begin locked = 0; waited = 0; end
    m_ig = ig; m_dg = dg; m_beat = beat;
  endtask

  initial forever begin
    obs_t e, g;
    @(negedge clk);
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {if_gnt, d_gnt, d_beat, if_stall, d_stall, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata};
      checks++;
      if (g === e) passed++;
      else $display("FAIL cyc%0d outputs got %h exp %h", cyc, g, e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; flush = 0; if_req = 0; d_req = 0; d_we = 0; d_cont = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    clr_in();
    // reset with random inputs, then quiet inputs
    v_rst = 1;
    repeat (3) begin
      v_ir = 1'($urandom); v_dr = 1'($urandom); v_we = 1'($urandom); v_ct = 1'($urandom);
      v_fl = 1'($urandom); v_ia = $urandom; v_da = $urandom; v_w0 = $urandom; v_w1 = $urandom;
      tick();
    end
    clr_in(); tick(); tick();
    // contention with single beats
    v_ir = 1; v_ia = 32'h40; v_dr = 1; v_da = 32'h10; v_w0 = 32'h11;
    repeat (5) tick();
    clr_in(); tick();
    // two-beat write with fetch waiting
    v_ir = 1; v_ia = 32'h44; v_dr = 1; v_we = 1; v_ct = 1; v_da = 32'h100; v_w0 = 32'hAA; v_w1 = 32'hBB;
    tick(); tick();
    clr_in(); tick();
    // flush during second beat
    v_ir = 1; v_ia = 32'h48; v_dr = 1; v_ct = 1; v_da = 32'h200;
    tick();
    v_fl = 1; tick();
    v_fl = 0; v_dr = 0; tick();
    clr_in(); tick();
    // starvation counter held across the lock
    v_ir = 1; v_ia = 32'h4C; v_dr = 1; v_da = 32'h300;
    tick();
    v_ct = 1; tick(); tick();
    v_ct = 0; tick(); tick();
    clr_in(); tick();
    // address wrap on second beat
    v_dr = 1; v_ct = 1; v_da = 32'hFFFF_FFFF;
    tick(); tick();
    clr_in(); tick();
    // async reset between the beats drops the second beat
    v_dr = 1; v_ct = 1; v_da = 32'h500; v_w0 = 32'h55; v_w1 = 32'h66;
    tick();
    v_rst = 1; tick();
    v_rst = 0; tick(); tick();
    clr_in(); tick();
    // randomized traffic obeying the request-hold protocol
    repeat (600) begin
      tick();
      if (m_ig) v_ir = 0;
      if (!v_ir && ($urandom % 3 != 0)) begin v_ir = 1; v_ia = $urandom; end
      if (m_dg && (m_beat || !v_ct)) v_dr = 0;
      if (!v_dr && ($urandom % 2 == 0)) begin
        v_dr = 1; v_we = 1'($urandom); v_ct = 1'($urandom);
        v_da = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
        v_w0 = $urandom; v_w1 = $urandom;
      end
      v_fl = ($urandom % 8 == 0);
    end
    clr_in(); tick(); tick();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL leftover got %0d pending exp 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
